// File: rtl/sifive_reset_sequencer_if.sv
// sifive_reset_sequencer_if: lock/request inputs and per-domain reset outputs of the reset sequencer
//   pll_locked    clock-lock status, already synchronized
//   sw_req        software reset request
//   wdog_req      watchdog reset request
//   domain_reset  active-high reset per domain, bit 0 released first
//   busy          high while any domain is held in reset
//   cause         last reset cause: 0 power-on, 1 software, 2 watchdog, 3 lock loss
//   master: sequencer side, slave: SoC/environment side
interface sifive_reset_sequencer_if #(
    parameter int DOMAINS = 4
);
    logic               pll_locked;
    logic               sw_req;
    logic               wdog_req;
    logic [DOMAINS-1:0] domain_reset;
    logic               busy;
    logic [1:0]         cause;
    modport master (input pll_locked, sw_req, wdog_req, output domain_reset, busy, cause);
    modport slave (output pll_locked, sw_req, wdog_req, input domain_reset, busy, cause);
endinterface

// File: rtl/sifive_reset_sequencer.sv
// sifive_reset_sequencer: waits for lock, holds all domains, then releases them one by one in index order
//   clock  always-on clock
//   reset  synchronous active-high reset of the sequencer
//   bus    sifive_reset_sequencer_if.master (lock/requests in, domain resets/busy/cause out)
//   Optional: define SIFIVE_RESET_SEQ_LOCK_WATCH_EN to return to WAIT_LOCK on lock loss after WAIT_LOCK
module sifive_reset_sequencer #(
    parameter int DOMAINS     = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int STEP_CYCLES = 16
) (
    input logic                      clock,
    input logic                      reset,
    sifive_reset_sequencer_if.master bus
);
    localparam int MAXC = HOLD_CYCLES > STEP_CYCLES ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(DOMAINS) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] LAST     = IW'(DOMAINS - 1);
    localparam logic [DOMAINS-1:0] ONE = DOMAINS'(1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, STEP, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DOMAINS-1:0] dom_q, dom_d;
    logic [1:0]         cause_q, cause_d;
    logic               lock_lost;

`ifdef SIFIVE_RESET_SEQ_LOCK_WATCH_EN
    assign lock_lost = !bus.pll_locked;
`else
    assign lock_lost = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            cause_q <= cause_d;
        end
    end

    // Lock loss outranks every other event once past WAIT_LOCK; in RUN watchdog outranks software.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        cause_d = cause_q;
        if (lock_lost && state_q != WAIT_LOCK) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            cause_d = 2'd3;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (bus.pll_locked) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        dom_d   = dom_q & ~ONE;
                        state_d = DOMAINS == 1 ? RUN : STEP;
                        idx_d   = IW'(1);
                        cnt_d   = STEP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                STEP: begin
                    if (cnt_q == '0) begin
                        dom_d   = dom_q & ~(ONE << idx_q);
                        state_d = idx_q == LAST ? RUN : STEP;
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = STEP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RUN: begin
                    if (bus.wdog_req || bus.sw_req) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                        idx_d   = '0;
                        dom_d   = '1;
                        cause_d = bus.wdog_req ? 2'd2 : 2'd1;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        bus.domain_reset = dom_q;
        bus.busy         = |dom_q;
        bus.cause        = cause_q;
    end
endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// tb_sifive_reset_sequencer: directed scoreboard bench for the reset sequencer
module tb_sifive_reset_sequencer;
    localparam int D   = 4;
    localparam int H   = 8;
    localparam int S   = 4;
    localparam int REL = H + (D - 1) * S;
`ifdef SIFIVE_RESET_SEQ_LOCK_WATCH_EN
    localparam bit WATCH = 1'b1;
`else
    localparam bit WATCH = 1'b0;
`endif

    typedef struct {
        logic [D-1:0] dom;
        logic         busy;
        logic [1:0]   cause;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   since = -1;
    logic [1:0] m_cause = 2'd0;

    sifive_reset_sequencer_if #(.DOMAINS(D)) bus ();

    sifive_reset_sequencer #(
        .DOMAINS(D),
        .HOLD_CYCLES(H),
        .STEP_CYCLES(S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Timeline model: "since" counts edges after the edge entering HOLD (t0), -1 while waiting for lock.
    task automatic model_edge();
        exp_t e;
        if (reset) begin
            since   = -1;
            m_cause = 2'd0;
        end else if (since < 0) begin
            if (bus.pll_locked) since = 0;
        end else if (WATCH && !bus.pll_locked) begin
            since   = -1;
            m_cause = 2'd3;
        end else if (since >= REL && (bus.wdog_req || bus.sw_req)) begin
            since   = -1;
            m_cause = bus.wdog_req ? 2'd2 : 2'd1;
        end else if (since < REL) begin
            since++;
        end
        for (int i = 0; i < D; i++) e.dom[i] = (since < 0) || (since < H + i * S);
        e.busy  = |e.dom;
        e.cause = m_cause;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n, input string tag);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clock);
            #1;
            e = sb.pop_front();
            checks++;
            assert (bus.domain_reset === e.dom) else begin
                errors++;
                $error("FAIL %s dom cyc%0d got %b exp %b", tag, k, bus.domain_reset, e.dom);
            end
            checks++;
            assert (bus.busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy cyc%0d got %b exp %b", tag, k, bus.busy, e.busy);
            end
            checks++;
            assert (bus.cause === e.cause) else begin
                errors++;
                $error("FAIL %s cause cyc%0d got %0d exp %0d", tag, k, bus.cause, e.cause);
            end
        end
    endtask

    initial begin
        bus.pll_locked = 1'b1;
        bus.sw_req     = 1'b0;
        bus.wdog_req   = 1'b0;
        cyc(2, "reset");
        reset = 1'b0;
        cyc(REL + 4, "poweron_seq");
        bus.sw_req = 1'b1;
        cyc(1, "sw_req");
        bus.sw_req = 1'b0;
        cyc(REL + 4, "sw_reseq");
        bus.sw_req   = 1'b1;
        bus.wdog_req = 1'b1;
        cyc(1, "sw_wdog_prio");
        bus.sw_req   = 1'b0;
        bus.wdog_req = 1'b0;
        cyc(4, "hold_pre");
        bus.sw_req = 1'b1;
        cyc(2, "sw_in_hold");
        bus.sw_req = 1'b0;
        cyc(REL, "wdog_reseq");
        reset          = 1'b1;
        bus.pll_locked = 1'b0;
        cyc(1, "reset_run");
        reset = 1'b0;
        cyc(50, "no_lock");
        bus.pll_locked = 1'b1;
        cyc(REL + 3, "late_lock");
        reset = 1'b1;
        cyc(1, "reset_again");
        reset = 1'b0;
        cyc(H + S + 2, "to_step");
        reset = 1'b1;
        cyc(1, "reset_in_step");
        reset = 1'b0;
        cyc(REL + 3, "after_step_reset");
        bus.pll_locked = 1'b0;
        cyc(3, "lock_drop_run");
        bus.pll_locked = 1'b1;
        cyc(REL + 3, "relock");
        bus.pll_locked = 1'b0;
        bus.sw_req     = 1'b1;
        bus.wdog_req   = 1'b1;
        cyc(1, "all_req_prio");
        bus.pll_locked = 1'b1;
        bus.sw_req     = 1'b0;
        bus.wdog_req   = 1'b0;
        cyc(REL + 3, "final_seq");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
